conv_1st_out_collect: RTL and testbench

Output collector directly downstream of the first-layer convolution systolic array and its controller. It captures each group of NPE parallel partial sums on the controller's valid pulse, adds a per-channel bias, rescales with saturation and optional ReLU, and buffers the results in a small group FIFO. A serializer then streams the results one at a time, tagged with channel and position, to the next layer over a valid/ready handshake.

---
 rtl/conv_1st_out_collect.sv | 235 +++++++++++++++++++++++
 tb/tb_conv_1st_out_collect.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_1st_out_collect.sv
// conv_1st_out_collect: bias, rescale and saturate first-layer conv psums, then serialize.
// Define CONV_1ST_RELU_EN to clamp negative results to zero before the group FIFO.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   valid_i             one-cycle group strobe from the array controller
//   weight_num_i        output channel of the strobed group
//   psum_i              NPE signed psums, lane k at [k*PSUM_W +: PSUM_W]
//   bias_we/addr/data   bias table write port (32 entries)
//   dout/dout_ch/idx    serialized result, its channel and position in channel
//   dout_valid/ready    output handshake
//   overflow            sticky, set when a group is dropped on a full FIFO
//   busy                pipeline or FIFO holds data
module conv_1st_out_collect #(
  parameter int NPE        = 6,
  parameter int PSUM_W     = 20,
  parameter int BIAS_W     = 16,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [4:0]            weight_num_i,
  input  logic [NPE*PSUM_W-1:0] psum_i,
  input  logic                  bias_we,
  input  logic [4:0]            bias_addr,
  input  logic [BIAS_W-1:0]     bias_data,
  output logic [OUT_W-1:0]      dout,
  output logic [4:0]            dout_ch,
  output logic [9:0]            dout_idx,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overflow,
  output logic                  busy
);

  localparam int SW = PSUM_W + 1;
  localparam int LW = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [LW-1:0] LAST = LW'(NPE - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [9:0] NPE10 = 10'(NPE);
  localparam logic signed [SW-1:0] OMAX = SW'((2**(OUT_W-1)) - 1);
  localparam logic signed [SW-1:0] OMIN = SW'(-(2**(OUT_W-1)));

  function automatic logic [OUT_W-1:0] scale(
    input logic signed [PSUM_W-1:0] p,
    input logic signed [BIAS_W-1:0] b
  );
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] v;
    logic [OUT_W-1:0] r;
    s = SW'(p) + SW'(b);
    v = s >>> SHIFT;
    if (v > OMAX)
      r = OMAX[OUT_W-1:0];
    else if (v < OMIN)
      r = OMIN[OUT_W-1:0];
    else
      r = v[OUT_W-1:0];
`ifdef CONV_1ST_RELU_EN
    if (r[OUT_W-1])
      r = '0;
`endif
    return r;
  endfunction

  logic [BIAS_W-1:0] bias_tab [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        bias_tab[i] <= '0;
    end else if (bias_we) begin
      bias_tab[bias_addr] <= bias_data;
    end
  end

  logic                  s1_valid;
  logic [NPE*PSUM_W-1:0] s1_psum;
  logic [4:0]            s1_ch;
  logic [4:0]            last_ch;
  logic                  seen;
  logic [9:0]            grp_cnt;
  logic [9:0]            grp_nxt;

  // Position counter restarts whenever the channel changes.
  assign grp_nxt = (seen && weight_num_i == last_ch) ?
                   grp_cnt + 10'd1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_psum  <= '0;
      s1_ch    <= '0;
      last_ch  <= '0;
      seen     <= 1'b0;
      grp_cnt  <= '0;
    end else begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_psum <= psum_i;
        s1_ch   <= weight_num_i;
        last_ch <= weight_num_i;
        seen    <= 1'b1;
        grp_cnt <= grp_nxt;
      end
    end
  end

  logic [NPE*OUT_W-1:0] s2_nxt;
  logic                 s2_valid;
  logic [NPE*OUT_W-1:0] s2_vals;
  logic [4:0]           s2_ch;
  logic [9:0]           s2_grp;

  always_comb begin
    s2_nxt = '0;
    for (int k = 0; k < NPE; k++)
      s2_nxt[k*OUT_W +: OUT_W] =
        scale(s1_psum[k*PSUM_W +: PSUM_W], bias_tab[s1_ch]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_vals  <= '0;
      s2_ch    <= '0;
      s2_grp   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_vals <= s2_nxt;
        s2_ch   <= s1_ch;
        s2_grp  <= grp_cnt;
      end
    end
  end

  logic [NPE*OUT_W-1:0] f_val [FIFO_DEPTH];
  logic [4:0]           f_ch  [FIFO_DEPTH];
  logic [9:0]           f_grp [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [LW-1:0]        lane;
  logic                 push;
  logic                 pop;

  // The head group leaves only once its last lane is accepted;
  // that same-cycle pop makes room for an incoming group.
  assign pop  = dout_valid & dout_ready & (lane == LAST);
  assign push = s2_valid & ((count != FULL) | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      f_val[wr_ptr] <= s2_vals;
      f_ch[wr_ptr]  <= s2_ch;
      f_grp[wr_ptr] <= s2_grp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (s2_valid & ~push)
        overflow <= 1'b1;
    end
  end

  logic                 adv;
  logic                 have;
  logic [PW-1:0]        sel_ptr;
  logic [LW-1:0]        sel_lane;
  logic [NPE*OUT_W-1:0] sel_vals;

  assign adv = ~dout_valid | dout_ready;

  // Pick the element to present once the output register frees:
  // next lane of the head, or lane 0 of the group behind it.
  always_comb begin
    have     = 1'b0;
    sel_ptr  = rd_ptr;
    sel_lane = '0;
    unique case (1'b1)
      !dout_valid: begin
        have = (count != '0);
      end
      dout_valid && lane != LAST: begin
        have     = 1'b1;
        sel_lane = lane + LW'(1);
      end
      dout_valid && lane == LAST: begin
        have    = (count > CW'(1));
        sel_ptr = rd_ptr + PW'(1);
      end
      default: ;
    endcase
  end

  assign sel_vals = f_val[sel_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_ch    <= '0;
      dout_idx   <= '0;
      dout_valid <= 1'b0;
      lane       <= '0;
    end else if (adv) begin
      dout_valid <= have;
      lane       <= have ? sel_lane : '0;
      if (have) begin
        dout     <= sel_vals[sel_lane*OUT_W +: OUT_W];
        dout_ch  <= f_ch[sel_ptr];
        dout_idx <= f_grp[sel_ptr] * NPE10 + 10'(sel_lane);
      end
    end
  end

  assign busy = s1_valid | s2_valid | (count != '0);

endmodule

// File: tb/tb_conv_1st_out_collect.sv
// tb_conv_1st_out_collect: directed and randomized-ready bench
// with a queue-based reference model of the output stream.
module tb_conv_1st_out_collect;

  localparam int NPE = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_i = 1'b0;
  logic [4:0]        weight_num_i = '0;
  logic [NPE*20-1:0] psum_i = '0;
  logic              bias_we = 1'b0;
  logic [4:0]        bias_addr = '0;
  logic [15:0]       bias_data = '0;
  logic [7:0]        dout;
  logic [4:0]        dout_ch;
  logic [9:0]        dout_idx;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic              overflow;
  logic              busy;

  always #5 clk = ~clk;

  conv_1st_out_collect dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .weight_num_i (weight_num_i),
    .psum_i       (psum_i),
    .bias_we      (bias_we),
    .bias_addr    (bias_addr),
    .bias_data    (bias_data),
    .dout         (dout),
    .dout_ch      (dout_ch),
    .dout_idx     (dout_idx),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .overflow     (overflow),
    .busy         (busy)
  );

  typedef struct {
    int d;
    int ch;
    int idx;
  } item_t;

  item_t exp_q[$];
  item_t cur;
  int    obs_d[$];
  int    obs_ch[$];
  int    obs_idx[$];
  int    checks = 0;
  int    errors = 0;
  int    n_acc = 0;
  int    tb_bias[32];
  int    ps[NPE];
  int    m_cnt = 0;
  int    last_ch = 0;
  bit    have_last = 1'b0;
  bit    done4 = 1'b0;

  // Reference result of one lane: floor((p+b)/2^8), clamp, optional ReLU.
  function automatic int model_val(int p, int b);
    int v;
    v = (p + b) >>> 8;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`ifdef CONV_1ST_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic write_bias(int a, int v);
    bias_we = 1'b1;
    bias_addr = 5'(a);
    bias_data = 16'(v);
    tb_bias[a] = v;
    @(posedge clk);
    #1;
    bias_we = 1'b0;
  endtask

  // Caller is aligned 1 time unit after a rising edge.
  task automatic send_group(int ch, bit keep);
    item_t it;
    if (!have_last || ch != last_ch) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % 1024;
    have_last = 1'b1;
    last_ch = ch;
    if (keep) begin
      for (int k = 0; k < NPE; k++) begin
        it.d = model_val(ps[k], tb_bias[ch]);
        it.ch = ch;
        it.idx = (m_cnt * NPE + k) % 1024;
        exp_q.push_back(it);
      end
    end
    valid_i = 1'b1;
    weight_num_i = 5'(ch);
    for (int k = 0; k < NPE; k++)
      psum_i[k*20 +: 20] = 20'(ps[k]);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_random();
    int acc0;
    acc0 = n_acc;
    done4 = 1'b0;
    fork
      begin
        int ch;
        ch = 1;
        for (int g = 0; g < 64; g++) begin
          int w;
          w = 0;
          while (g - (n_acc - acc0) / NPE >= 3 && w < 300) begin
            @(posedge clk);
            #1;
            w++;
          end
          if ($urandom_range(0, 2) == 0) ch = $urandom_range(0, 31);
          for (int k = 0; k < NPE; k++)
            ps[k] = int'($urandom_range(0, 1048575)) - 524288;
          send_group(ch, 1'b1);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done4 = 1'b1;
      end
      begin
        int k;
        k = 0;
        while ((!done4 || exp_q.size() != 0) && k < 8000) begin
          @(posedge clk);
          #1;
          dout_ready = ($urandom_range(0, 3) != 0);
          k++;
        end
        dout_ready = 1'b1;
      end
    join
  endtask

  bit          stall_p = 1'b0;
  logic [7:0]  p_d;
  logic [4:0]  p_c;
  logic [9:0]  p_i;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        checks++;
        if (dout !== p_d || dout_ch !== p_c ||
            dout_idx !== p_i || dout_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: got %0d/%0d/%0d v%0b required %0d/%0d/%0d v1",
                   dout, dout_ch, dout_idx, dout_valid, p_d, p_c, p_i);
        end
      end
      if (dout_valid && dout_ready) begin
        checks++;
        n_acc++;
        obs_d.push_back(int'($signed(dout)));
        obs_ch.push_back(int'(dout_ch));
        obs_idx.push_back(int'(dout_idx));
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got %0d ch%0d idx%0d required no output",
                   $signed(dout), dout_ch, dout_idx);
        end else begin
          cur = exp_q.pop_front();
          if (int'($signed(dout)) != cur.d || int'(dout_ch) != cur.ch ||
              int'(dout_idx) != cur.idx) begin
            errors++;
            $display("FAIL stream: got %0d ch%0d idx%0d required %0d ch%0d idx%0d",
                     $signed(dout), dout_ch, dout_idx, cur.d, cur.ch, cur.idx);
          end
        end
      end
      stall_p = dout_valid && !dout_ready;
      p_d = dout;
      p_c = dout_ch;
      p_i = dout_idx;
    end
  end

  initial begin
    int base;
    int lat;
    int acc0;
    for (int i = 0; i < 32; i++) tb_bias[i] = 0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_ch", int'(dout_ch), 0);
    chk("rst_idx", int'(dout_idx), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b1;

    write_bias(3, 100);
    ps = '{25600, -25600, 0, 300, -1, 32767};
    base = obs_d.size();
    send_group(3, 1'b1);
    lat = 1;
    while (!dout_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 4);
    wait_drain("t1_drain");
    chk("t1_dout", obs_d[base], 100);
    chk("t1_ch", obs_ch[base], 3);
    chk("t1_idx", obs_idx[base], 0);

    ps = '{524287, -524288, 1000, -1000, 0, 0};
    base = obs_d.size();
    send_group(0, 1'b1);
    wait_drain("t2_drain");
    chk("sat_hi", obs_d[base], 127);
`ifdef CONV_1ST_RELU_EN
    chk("sat_lo", obs_d[base+1], 0);
`else
    chk("sat_lo", obs_d[base+1], -128);
`endif

    write_bias(5, -300);
    write_bias(6, 1000);
    ps = '{2560, -2560, 70000, -70000, 12345, -9};
    base = obs_d.size();
    send_group(5, 1'b1);
    send_group(5, 1'b1);
    send_group(6, 1'b1);
    wait_drain("t3_drain");
    chk("idx_g0", obs_idx[base+5], 5);
    chk("idx_g1a", obs_idx[base+6], 6);
    chk("idx_g1b", obs_idx[base+11], 11);
    chk("idx_ch6", obs_idx[base+12], 0);
    chk("ch6", obs_ch[base+12], 6);

    for (int i = 0; i < 32; i++)
      write_bias(i, int'($urandom_range(0, 65535)) - 32768);
    run_random();
    wait_drain("t4_drain");
    chk("t4_no_ovf", int'(overflow), 0);

    dout_ready = 1'b0;
    ps = '{1000, 2000, -3000, 4000, -5000, 6000};
    for (int g = 0; g < 5; g++) send_group(9, g < 4);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_busy", int'(busy), 1);
    chk("ovf_vld", int'(dout_valid), 1);
    acc0 = n_acc;
    dout_ready = 1'b1;
    wait_drain("t5_drain");
    chk("ovf_count", n_acc - acc0, 24);
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_idle", int'(busy), 0);

    dout_ready = 1'b0;
    ps = '{100, 200, 300, 400, 500, 600};
    send_group(2, 1'b1);
    send_group(2, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", int'(dout_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_ch", int'(dout_ch), 0);
    chk("mid_rst_idx", int'(dout_idx), 0);
    exp_q.delete();
    have_last = 1'b0;
    for (int i = 0; i < 32; i++) tb_bias[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dout_ready = 1'b1;
    acc0 = n_acc;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst_none", n_acc - acc0, 0);
    chk("post_rst_busy", int'(busy), 0);

    ps = '{25600, 0, 0, 0, 0, 0};
    base = obs_d.size();
    send_group(3, 1'b1);
    wait_drain("t6_drain");
    chk("t6_dout", obs_d[base], 100);
    chk("t6_idx", obs_idx[base], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
